// File: rtl/nios_debug_jtag_scan_master.sv
// Virtual-JTAG scan master for a Nios debug slave: walks UIR/CDR/SDR/UDR/RTI at a
// divided tick rate, shifting cmd_data out on tdi and capturing tdo into rsp_data.
module nios_debug_jtag_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tdi,
    input  logic                tdo,
    output logic                tck_en
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DR_WIDTH + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [DR_WIDTH-1:0] sr, sr_nxt;
    logic [1:0]          ir_nxt;
    logic                accept_c;
    logic                tick_c;
    logic                cmd_ready_nxt;
    logic                rsp_valid_nxt;
    logic                vs_uir_nxt;
    logic                vs_cdr_nxt;
    logic                vs_sdr_nxt;
    logic                vs_udr_nxt;
    logic                rti_nxt;
    logic                tdi_nxt;
    logic                tck_en_nxt;

    // The shift register doubles as the response holding register.
    assign rsp_data = sr;

    // State, counters, data path and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            sr             <= '0;
            ir_in          <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            tdi            <= 1'b0;
            tck_en         <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_cnt        <= bit_cnt_nxt;
            sr             <= sr_nxt;
            ir_in          <= ir_nxt;
            cmd_ready      <= cmd_ready_nxt;
            rsp_valid      <= rsp_valid_nxt;
            vs_uir         <= vs_uir_nxt;
            vs_cdr         <= vs_cdr_nxt;
            vs_sdr         <= vs_sdr_nxt;
            vs_udr         <= vs_udr_nxt;
            jtag_state_rti <= rti_nxt;
            tdi            <= tdi_nxt;
            tck_en         <= tck_en_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next values so they line up with the state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt == TICK_LAST) ? '0 : cnt + CNT_W'(1);
        bit_cnt_nxt = bit_cnt;
        sr_nxt      = sr;
        ir_nxt      = ir_in;
        accept_c    = cmd_valid && (state == ST_IDLE);
        tick_c      = (cnt == TICK_LAST) && (state != ST_IDLE) && (state != ST_RESP);

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt = ST_UIR;
                    cnt_nxt   = '0;
                    sr_nxt    = cmd_data;
                    ir_nxt    = cmd_ir;
                end
            end
            ST_UIR: begin
                if (tick_c) state_nxt = ST_CDR;
            end
            ST_CDR: begin
                if (tick_c) begin
                    state_nxt   = ST_SDR;
                    bit_cnt_nxt = '0;
                end
            end
            ST_SDR: begin
                if (tick_c) begin
                    sr_nxt = {tdo, sr[DR_WIDTH-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_UDR;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_UDR: begin
                if (tick_c) state_nxt = ST_RTI;
            end
            ST_RTI: begin
                if (tick_c) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == ST_IDLE);
        rsp_valid_nxt = (state_nxt == ST_RESP);
        vs_uir_nxt    = (state_nxt == ST_UIR);
        vs_cdr_nxt    = (state_nxt == ST_CDR);
        vs_sdr_nxt    = (state_nxt == ST_SDR);
        vs_udr_nxt    = (state_nxt == ST_UDR);
        rti_nxt       = (state_nxt == ST_IDLE) || (state_nxt == ST_RTI) || (state_nxt == ST_RESP);
        tdi_nxt       = (state_nxt == ST_SDR) ? sr_nxt[0] : 1'b0;
        tck_en_nxt    = (cnt_nxt == TICK_LAST) && (state_nxt != ST_IDLE) && (state_nxt != ST_RESP);
    end

endmodule

// File: tb/tb_nios_debug_jtag_scan_master.sv
// Scoreboard bench: u_dut (TICK_DIV=4) with a pattern-driven tdo, u_dut1 (TICK_DIV=1) in tdi->tdo loopback.
module tb_nios_debug_jtag_scan_master;

    localparam int unsigned DW = 38;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]    cmd_ir, ir_in;
    logic [DW-1:0] cmd_data, rsp_data;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, tdi, tdo, tck_en;

    logic          cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
    logic [1:0]    cmd_ir1, ir_in1;
    logic [DW-1:0] cmd_data1, rsp_data1;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1, tdi1, tdo1, tck_en1;

    assign tdo1 = tdi1;

    nios_debug_jtag_scan_master #(.DR_WIDTH(DW), .TICK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti),
        .tdi(tdi), .tdo(tdo), .tck_en(tck_en)
    );

    nios_debug_jtag_scan_master #(.DR_WIDTH(DW), .TICK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .ir_in(ir_in1), .vs_uir(vs_uir1), .vs_cdr(vs_cdr1),
        .vs_sdr(vs_sdr1), .vs_udr(vs_udr1), .jtag_state_rti(rti1),
        .tdi(tdi1), .tdo(tdo1), .tck_en(tck_en1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboards: expected rsp_data pushed at stimulus time, popped on each handshake.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp1_q[$];

    // u_dut monitor state
    logic [DW-1:0] tdo_pat = '0;
    logic [DW-1:0] tdi_cap, exp_tdi;
    logic [1:0]    exp_ir;
    int            sdr_k = 0;
    int            acc_cyc = 0, hs_edge = 0, nrsp = 0;
    int            t_uir, t_cdr, t_sdr, t_udr, viol;
    logic          prev_uir = 1'b0, prev_rv = 1'b0;

    always @(negedge clk) begin : mon
        if (reset) begin
            sdr_k    = 0;
            prev_uir = 1'b0;
            prev_rv  = 1'b0;
        end else begin
            if (vs_uir && !prev_uir) begin
                acc_cyc = cyc;
                t_uir = 0; t_cdr = 0; t_sdr = 0; t_udr = 0; viol = 0;
                tdi_cap = '0;
                exp_tdi = cmd_data;
                exp_ir  = cmd_ir;
            end
            if (!vs_sdr) sdr_k = 0;
            // Present the next tdo bit ahead of each sampling edge and record tdi.
            if (vs_sdr && tck_en) begin
                if (sdr_k < int'(DW)) begin
                    tdo = tdo_pat[sdr_k];
                    tdi_cap[sdr_k] = tdi;
                end
                sdr_k++;
            end
            if (tck_en) begin
                if (vs_uir) t_uir++;
                if (vs_cdr) t_cdr++;
                if (vs_sdr) t_sdr++;
                if (vs_udr) t_udr++;
            end
            if ((32'(vs_uir) + 32'(vs_cdr) + 32'(vs_sdr) + 32'(vs_udr)) > 32'd1 ||
                ((vs_uir | vs_cdr | vs_sdr | vs_udr) && jtag_state_rti))
                viol++;
            if (rsp_valid && !prev_rv) begin
                check("latency", 64'(cyc - acc_cyc), 64'd168);
                check("tick_seq", 64'({8'(t_uir), 8'(t_cdr), 8'(t_sdr), 8'(t_udr)}),
                      64'({8'd1, 8'd1, 8'd38, 8'd1}));
                check("seq_overlap", 64'(viol), 64'd0);
                check("tdi_serial", 64'(tdi_cap), 64'(exp_tdi));
                check("ir_in", 64'(ir_in), 64'(exp_ir));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp got=%0h want=none", rsp_data);
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
                end
                hs_edge = cyc + 1;
                nrsp++;
            end
            prev_uir = vs_uir;
            prev_rv  = rsp_valid;
        end
    end

    // u_dut1 monitor state
    logic [DW-1:0] tdi_cap1, exp_tdi1;
    logic [1:0]    exp_ir1;
    int            k1 = 0, acc1 = 0, tck1 = 0, nrsp1 = 0;
    logic          prev_uir1 = 1'b0, prev_rv1 = 1'b0;

    always @(negedge clk) begin : mon1
        if (reset) begin
            prev_uir1 = 1'b0;
            prev_rv1  = 1'b0;
        end else begin
            if (vs_uir1 && !prev_uir1) begin
                acc1 = cyc; tck1 = 0; k1 = 0;
                tdi_cap1 = '0;
                exp_tdi1 = cmd_data1;
                exp_ir1  = cmd_ir1;
            end
            if (tck_en1) tck1++;
            if (vs_sdr1 && tck_en1) begin
                if (k1 < int'(DW)) tdi_cap1[k1] = tdi1;
                k1++;
            end
            if (rsp_valid1 && !prev_rv1) begin
                check("lb_latency", 64'(cyc - acc1), 64'd42);
                check("lb_tck_every_clk", 64'(tck1), 64'd42);
                check("lb_tdi_serial", 64'(tdi_cap1), 64'(exp_tdi1));
                check("lb_ir_in", 64'(ir_in1), 64'(exp_ir1));
            end
            if (rsp_valid1 && rsp_ready1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lb_unexpected_rsp got=%0h want=none", rsp_data1);
                end else begin
                    check("lb_rsp_data", 64'(rsp_data1), 64'(exp1_q.pop_front()));
                end
                nrsp1++;
            end
            prev_uir1 = vs_uir1;
            prev_rv1  = rsp_valid1;
        end
    end

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=timeout want=event", name);
    endtask

    task automatic wait_rsp(input int n0);
        int t = 0;
        while (nrsp == n0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (nrsp == n0) fail_timeout("rsp_wait");
    endtask

    task automatic run_scan(input logic [1:0] ir, input logic [DW-1:0] data,
                            input logic [DW-1:0] pat, input bit wait_done);
        int n0 = nrsp;
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) fail_timeout("cmd_ready_wait");
        cmd_ir   = ir;
        cmd_data = data;
        tdo_pat  = pat;
        exp_q.push_back(pat);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (wait_done) wait_rsp(n0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_ir_in"}, 64'(ir_in), 64'd0);
        check({tag, "_vs"}, 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        check({tag, "_rti"}, 64'(jtag_state_rti), 64'd1);
        check({tag, "_tdi"}, 64'(tdi), 64'd0);
        check({tag, "_tck_en"}, 64'(tck_en), 64'd0);
    endtask

    logic [DW-1:0] bd [3] = '{38'h01_2345_6789, 38'h3A_BCDE_F012, 38'h10_0000_0001};
    logic [DW-1:0] bp [3] = '{38'h2F_F00F_5AA5, 38'h00_0000_0001, 38'h20_8421_8421};

    initial begin
        int t;
        int bad;
        int n0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b1; tdo = 1'b0;
        cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_data1 = '0; rsp_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Arbitrary tdo pattern comes back as rsp_data; tdi replays cmd_data LSB-first.
        run_scan(2'b10, 38'h0A_1234_5678, 38'h15_0F0F_3C3C, 1'b1);
        // Constant tdo=1 captures all ones.
        run_scan(2'b01, 38'h3F_0000_FFFF, 38'h3F_FFFF_FFFF, 1'b1);

        // Backpressure: response must hold for 50 clk, stray requests ignored.
        rsp_ready = 1'b0;
        n0 = nrsp;
        run_scan(2'b11, 38'h25_5555_AAAA, 38'h00_C3C3_1E1E, 1'b0);
        t = 0;
        while (!rsp_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) fail_timeout("bp_rsp_valid");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cmd_valid = (i % 5 == 0);
            cmd_ir    = 2'b00;
            cmd_data  = 38'h3F_FFFF_0000;
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 38'h00_C3C3_1E1E || cmd_ready) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        check("bp_ir_in_held", 64'(ir_in), 64'd3);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(n0);
        @(negedge clk);
        check("bp_no_stray_scan", 64'({vs_uir, cmd_ready}), 64'b01);

        // Reset in the middle of SDR aborts the scan with no response.
        n0 = nrsp;
        run_scan(2'b10, 38'h15_5555_5555, 38'h2A_AAAA_AAAA, 1'b0);
        t = 0;
        while (sdr_k < 20 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sdr_k < 20) fail_timeout("sdr_tick20");
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("abort_no_rsp", 64'(bad), 64'd0);
        check("abort_no_handshake", 64'(nrsp - n0), 64'd0);

        // A request presented with reset release is accepted on the first clk.
        n0 = nrsp;
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        cmd_ir    = 2'b01;
        cmd_data  = 38'h33_CCCC_3333;
        tdo_pat   = 38'h0C_3333_CCCC;
        exp_q.push_back(38'h0C_3333_CCCC);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("first_clk_accept", 64'(vs_uir), 64'd1);
        cmd_valid = 1'b0;
        wait_rsp(n0);

        // Back-to-back with cmd_valid and rsp_ready held: one IDLE clk between scans.
        n0 = nrsp;
        @(negedge clk);
        cmd_ir    = 2'b10;
        cmd_data  = bd[0];
        tdo_pat   = bp[0];
        exp_q.push_back(bp[0]);
        cmd_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            t = 0;
            while (!rsp_valid && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!rsp_valid) fail_timeout("b2b_rsp_valid");
            #1;
            if (i < 3) begin
                cmd_data = bd[i];
                tdo_pat  = bp[i];
                exp_q.push_back(bp[i]);
            end else begin
                cmd_valid = 1'b0;
            end
            repeat (3) @(negedge clk);
            if (i < 3) check("b2b_gap", 64'(acc_cyc - hs_edge), 64'd1);
        end
        t = 0;
        while (nrsp < n0 + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b2b_count", 64'(nrsp - n0), 64'd3);

        // Loopback at TICK_DIV=1: the word rotates through all 38 positions and returns unchanged.
        n0 = nrsp1;
        @(negedge clk);
        cmd_ir1   = 2'b01;
        cmd_data1 = 38'h2_A5A5_A5A5;
        exp1_q.push_back(38'h2_A5A5_A5A5);
        cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        t = 0;
        while (nrsp1 == n0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (nrsp1 == n0) fail_timeout("lb_rsp_wait");
        check("lb_ir_hold", 64'(ir_in1), 64'd1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("lb_sb_empty", 64'(exp1_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
